multicycle_control_32: RTL and testbench

//  Multicycle MIPS control unit: successor to the single-cycle opcode decoder.
//  A per-instruction FSM sequences fetch/decode/execute/memory/writeback and

---
 rtl/mips_ctrl_pkg.sv | 72 +++++++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/multicycle_control_32.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control_32.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// constants, datapath mux selects and the control-word payload.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_RWB     = 4'd7,
        S_ADDI_EX = 4'd8,
        S_ADDI_WB = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_JR      = 4'd12,
        S_JAL     = 4'd13,
        S_TRAP    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR = 2'b01;
    localparam logic [1:0] MEMTOREG_PC  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] ALUSRCB_RT    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_toreg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the cycle
// on which the wait limit is reached; a ready in that same cycle suppresses it.
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned WAIT_W       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic timeout_c
);

    localparam bit               ENABLED = (MEM_WAIT_MAX != 0);
    localparam logic [WAIT_W-1:0] LAST   = WAIT_W'((MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1);

    logic [WAIT_W-1:0] cnt;

    // cnt holds the number of not-ready cycles already spent in this access
    assign timeout_c = ENABLED && active && !ready && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active || ready || timeout_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control_32.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// for the shared-ALU/shared-memory datapath, with memory timeout and sticky TRAP.
module multicycle_control_32
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned WAIT_W       = 4,
    parameter bit          ENABLE_JAL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_toreg,
    output logic [1:0] reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       err_illegal_opcode,
    output logic       err_mem_timeout
);

    state_t     state_q, state_d;
    logic [5:0] op_q;
    logic       err_ill_q, err_to_q;
    logic       wait_active_c, timeout_c, illegal_c;
    ctrl_t      ctrl_c;

    assign wait_active_c = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX),
        .WAIT_W       (WAIT_W)
    ) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (wait_active_c),
        .ready     (mem_ready),
        .timeout_c (timeout_c)
    );

    // Next-state logic; opcode/funct only matter in DECODE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (timeout_c) state_d = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = ENABLE_JAL ? S_JAL : S_TRAP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:  state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)      state_d = S_MEMWB;
                else if (timeout_c) state_d = S_TRAP;
            end
            S_MEMWR: begin
                if (mem_ready)      state_d = S_FETCH;
                else if (timeout_c) state_d = S_TRAP;
            end
            S_EXEC_R:  state_d = S_RWB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_MEMWB, S_RWB, S_ADDI_WB, S_BRANCH, S_JUMP, S_JR, S_JAL: state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_TRAP;
        endcase
    end

    assign illegal_c = (state_q == S_DECODE) && (state_d == S_TRAP);

    // Control word decoded from state; ir/pc writes also follow mem_ready/zero
    always_comb begin
        ctrl_c = CTRL_IDLE;
        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = ALUSRCB_FOUR;
                ctrl_c.alu_op    = ALUOP_ADD;
                ctrl_c.pc_src    = PCSRC_ALU;
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = ALUSRCB_IMMSH;
                ctrl_c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDI_EX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = ALUSRCB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = REGDST_RT;
                ctrl_c.mem_toreg = MEMTOREG_MDR;
            end
            S_MEMWR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.iord      = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = ALUSRCB_RT;
                ctrl_c.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = REGDST_RD;
                ctrl_c.mem_toreg = MEMTOREG_ALU;
            end
            S_ADDI_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = REGDST_RT;
            end
            S_BRANCH: begin
                // op_q[0] distinguishes bne from beq
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = ALUSRCB_RT;
                ctrl_c.alu_op    = ALUOP_SUB;
                ctrl_c.pc_src    = PCSRC_ALUOUT;
                ctrl_c.pc_write  = zero ^ op_q[0];
            end
            S_JUMP: begin
                ctrl_c.pc_src   = PCSRC_JUMP;
                ctrl_c.pc_write = 1'b1;
            end
            S_JR: begin
                ctrl_c.pc_src   = PCSRC_RS;
                ctrl_c.pc_write = 1'b1;
            end
            S_JAL: begin
                ctrl_c.pc_src    = PCSRC_JUMP;
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = REGDST_RA;
                ctrl_c.mem_toreg = MEMTOREG_PC;
            end
            default: ctrl_c = CTRL_IDLE;
        endcase
    end

    // State, latched opcode and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            err_ill_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= opcode;
            if (illegal_c)           err_ill_q <= 1'b1;
            if (timeout_c)           err_to_q  <= 1'b1;
        end
    end

    // Strobes drop as soon as reset asserts, even mid-access
    assign pc_write  = ctrl_c.pc_write  & rst_n;
    assign ir_write  = ctrl_c.ir_write  & rst_n;
    assign mem_read  = ctrl_c.mem_read  & rst_n;
    assign mem_write = ctrl_c.mem_write & rst_n;
    assign reg_write = ctrl_c.reg_write & rst_n;

    assign iord      = ctrl_c.iord;
    assign mem_toreg = ctrl_c.mem_toreg;
    assign reg_dst   = ctrl_c.reg_dst;
    assign alu_src_a = ctrl_c.alu_src_a;
    assign alu_src_b = ctrl_c.alu_src_b;
    assign alu_op    = ctrl_c.alu_op;
    assign pc_src    = ctrl_c.pc_src;
    assign state     = state_q;

    assign err_illegal_opcode = err_ill_q;
    assign err_mem_timeout    = err_to_q;

endmodule

// File: tb/tb_multicycle_control_32.sv
// Bench for multicycle_control_32: per-cycle expected control words are queued
// as stimulus is applied and compared against the DUT at the falling edge.
`timescale 1ns/1ps
module tb_multicycle_control_32;
    import mips_ctrl_pkg::*;

    localparam logic [5:0] OP_X = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a;
    logic [1:0] mem_toreg, reg_dst, alu_src_b, alu_op, pc_src;
    logic [3:0] state;
    logic       err_illegal_opcode, err_mem_timeout;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write, ir_write, iord, mem_read, mem_write;
        logic [1:0] mem_toreg, reg_dst;
        logic       reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       e_ill, e_to;
    } obs_t;

    typedef struct packed {
        logic       ready, zero;
        logic [5:0] op, fn;
        logic [3:0] st;
        logic       ill, to;
    } stim_t;

    stim_t      stim[$];
    obs_t       sb[$];
    logic [5:0] dec_op = 6'd0;
    int         n_cmp = 0;
    int         n_err = 0;

    multicycle_control_32 dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .mem_toreg(mem_toreg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .state(state),
        .err_illegal_opcode(err_illegal_opcode), .err_mem_timeout(err_mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o = '{st: state, pc_write: pc_write, ir_write: ir_write, iord: iord,
              mem_read: mem_read, mem_write: mem_write, mem_toreg: mem_toreg,
              reg_dst: reg_dst, reg_write: reg_write, alu_src_a: alu_src_a,
              alu_src_b: alu_src_b, alu_op: alu_op, pc_src: pc_src,
              e_ill: err_illegal_opcode, e_to: err_mem_timeout};
        return o;
    endfunction

    // Reference control word per state, written from the control table
    function automatic obs_t model(stim_t s, logic [5:0] dop, logic in_rst);
        obs_t m;
        m = '0;
        m.st = s.st; m.e_ill = s.ill; m.e_to = s.to;
        case (state_t'(s.st))
            S_FETCH:   begin m.mem_read = 1'b1; m.alu_src_b = 2'b01;
                             m.ir_write = s.ready; m.pc_write = s.ready; end
            S_DECODE:  m.alu_src_b = 2'b11;
            S_MEMADR:  begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; end
            S_MEMRD:   begin m.mem_read = 1'b1; m.iord = 1'b1; end
            S_MEMWB:   begin m.reg_write = 1'b1; m.mem_toreg = 2'b01; end
            S_MEMWR:   begin m.mem_write = 1'b1; m.iord = 1'b1; end
            S_EXEC_R:  begin m.alu_src_a = 1'b1; m.alu_op = 2'b10; end
            S_RWB:     begin m.reg_write = 1'b1; m.reg_dst = 2'b01; end
            S_ADDI_EX: begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; end
            S_ADDI_WB: m.reg_write = 1'b1;
            S_BRANCH:  begin m.alu_src_a = 1'b1; m.alu_op = 2'b01; m.pc_src = 2'b01;
                             m.pc_write = (dop == 6'b000100) ? s.zero : !s.zero; end
            S_JUMP:    begin m.pc_src = 2'b10; m.pc_write = 1'b1; end
            S_JR:      begin m.pc_src = 2'b11; m.pc_write = 1'b1; end
            S_JAL:     begin m.pc_src = 2'b10; m.pc_write = 1'b1; m.reg_write = 1'b1;
                             m.reg_dst = 2'b10; m.mem_toreg = 2'b10; end
            default:   ;
        endcase
        if (in_rst) begin
            m.pc_write = 1'b0; m.ir_write = 1'b0; m.mem_read = 1'b0;
            m.mem_write = 1'b0; m.reg_write = 1'b0;
        end
        return m;
    endfunction

    function automatic void add(logic r, logic z, logic [5:0] op, logic [5:0] fn,
                                state_t st, logic ill, logic to);
        stim.push_back('{ready: r, zero: z, op: op, fn: fn, st: st, ill: ill, to: to});
    endfunction

    task automatic apply(stim_t s);
        mem_ready = s.ready; zero = s.zero; opcode = s.op; funct = s.fn;
        if (s.st == S_DECODE) dec_op = s.op;
        sb.push_back(model(s, dec_op, 1'b0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = OP_X; funct = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        rst_n = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = OP_X; funct = 6'd0;
        #1 rst_n = 1'b0;
        #2;
        sb.push_back(model('{ready: 1'b0, zero: 1'b0, op: OP_X, fn: 6'd0,
                             st: S_FETCH, ill: 1'b0, to: 1'b0}, 6'd0, 1'b1));
        got = sample(); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset got=%h exp=%h", got, exp); end
        do_reset();
    endtask

    task automatic test_lw_wait();
        obs_t got, exp;
        add(0, 0, OP_X, 0, S_FETCH, 0, 0);
        add(0, 0, OP_X, 0, S_FETCH, 0, 0);
        add(1, 0, OP_X, 0, S_FETCH, 0, 0);
        add(0, 0, OP_LW, 6'h2A, S_DECODE, 0, 0);
        add(0, 0, OP_X, 0, S_MEMADR, 0, 0);
        add(0, 0, OP_X, 0, S_MEMRD, 0, 0);
        add(0, 0, OP_X, 0, S_MEMRD, 0, 0);
        add(1, 0, OP_X, 0, S_MEMRD, 0, 0);
        add(0, 0, OP_X, 0, S_MEMWB, 0, 0);
        add(0, 0, OP_X, 0, S_FETCH, 0, 0);
        foreach (stim[i]) begin
            apply(stim[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL lw_wait[%0d] got=%h exp=%h", i, got, exp); end
            @(posedge clk); #1;
        end
        stim.delete();
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        add(1, 0, OP_X, 0, S_FETCH, 0, 0);
        add(0, 0, OP_SW, 0, S_DECODE, 0, 0);
        add(0, 0, OP_X, 0, S_MEMADR, 0, 0);
        add(1, 0, OP_X, 0, S_MEMWR, 0, 0);
        add(1, 0, OP_X, 0, S_FETCH, 0, 0);
        add(0, 0, OP_RTYPE, 6'h20, S_DECODE, 0, 0);
        add(0, 0, OP_X, 0, S_EXEC_R, 0, 0);
        add(0, 0, OP_X, 0, S_RWB, 0, 0);
        add(1, 0, OP_X, 0, S_FETCH, 0, 0);
        add(0, 0, OP_ADDI, FUNCT_JR, S_DECODE, 0, 0);
        add(0, 0, OP_X, 0, S_ADDI_EX, 0, 0);
        add(0, 0, OP_X, 0, S_ADDI_WB, 0, 0);
        foreach (stim[i]) begin
            apply(stim[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, exp); end
            @(posedge clk); #1;
        end
        stim.delete();
    endtask

    task automatic test_jumps();
        obs_t got, exp;
        add(1, 0, OP_X, 0, S_FETCH, 0, 0);
        add(0, 0, OP_RTYPE, FUNCT_JR, S_DECODE, 0, 0);
        add(1, 0, OP_X, 0, S_JR, 0, 0);
        add(1, 0, OP_X, 0, S_FETCH, 0, 0);
        add(0, 0, OP_J, 0, S_DECODE, 0, 0);
        add(0, 0, OP_X, 0, S_JUMP, 0, 0);
        add(1, 0, OP_X, 0, S_FETCH, 0, 0);
        add(0, 0, OP_JAL, 0, S_DECODE, 0, 0);
        add(0, 0, OP_X, 0, S_JAL, 0, 0);
        foreach (stim[i]) begin
            apply(stim[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL jumps[%0d] got=%h exp=%h", i, got, exp); end
            @(posedge clk); #1;
        end
        stim.delete();
    endtask

    task automatic test_branch();
        obs_t got, exp;
        for (int k = 0; k < 4; k++) begin
            add(1, 0, OP_X, 0, S_FETCH, 0, 0);
            add(0, !k[0], (k < 2) ? OP_BEQ : OP_BNE, 0, S_DECODE, 0, 0);
            add(0, k[0], OP_X, 0, S_BRANCH, 0, 0);
        end
        add(0, 0, OP_X, 0, S_FETCH, 0, 0);
        foreach (stim[i]) begin
            apply(stim[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL branch[%0d] got=%h exp=%h", i, got, exp); end
            @(posedge clk); #1;
        end
        stim.delete();
    endtask

    task automatic test_illegal();
        obs_t got, exp;
        add(1, 0, OP_X, 0, S_FETCH, 0, 0);
        add(0, 0, 6'b111111, 0, S_DECODE, 0, 0);
        add(1, 1, OP_LW, 0, S_TRAP, 1, 0);
        add(1, 0, OP_RTYPE, FUNCT_JR, S_TRAP, 1, 0);
        add(0, 0, OP_X, 0, S_TRAP, 1, 0);
        foreach (stim[i]) begin
            apply(stim[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL illegal[%0d] got=%h exp=%h", i, got, exp); end
            @(posedge clk); #1;
        end
        stim.delete();
        do_reset();
        add(0, 0, OP_X, 0, S_FETCH, 0, 0);
        foreach (stim[i]) begin
            apply(stim[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL illegal_clear[%0d] got=%h exp=%h", i, got, exp); end
            @(posedge clk); #1;
        end
        stim.delete();
    endtask

    task automatic test_mem_timeout();
        obs_t got, exp;
        // ready on the 15th waiting cycle still completes the store
        add(1, 0, OP_X, 0, S_FETCH, 0, 0);
        add(0, 0, OP_SW, 0, S_DECODE, 0, 0);
        add(0, 0, OP_X, 0, S_MEMADR, 0, 0);
        for (int k = 0; k < 14; k++) add(0, 0, OP_X, 0, S_MEMWR, 0, 0);
        add(1, 0, OP_X, 0, S_MEMWR, 0, 0);
        add(1, 0, OP_X, 0, S_FETCH, 0, 0);
        add(0, 0, OP_SW, 0, S_DECODE, 0, 0);
        add(0, 0, OP_X, 0, S_MEMADR, 0, 0);
        for (int k = 0; k < 15; k++) add(0, 0, OP_X, 0, S_MEMWR, 0, 0);
        add(1, 0, OP_X, 0, S_TRAP, 0, 1);
        add(1, 0, OP_X, 0, S_TRAP, 0, 1);
        foreach (stim[i]) begin
            apply(stim[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL mem_timeout[%0d] got=%h exp=%h", i, got, exp); end
            @(posedge clk); #1;
        end
        stim.delete();
        do_reset();
    endtask

    task automatic test_reset_mid_write();
        obs_t got, exp;
        add(1, 0, OP_X, 0, S_FETCH, 0, 0);
        add(0, 0, OP_SW, 0, S_DECODE, 0, 0);
        add(0, 0, OP_X, 0, S_MEMADR, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, OP_X, 0, S_MEMWR, 0, 0);
        foreach (stim[i]) begin
            apply(stim[i]);
            @(negedge clk);
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL reset_mid_write[%0d] got=%h exp=%h", i, got, exp); end
            @(posedge clk); #1;
        end
        stim.delete();
        n_cmp++;
        if (mem_write !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_mem_write got=%b exp=1", mem_write);
        end
        #1 rst_n = 1'b0;
        #1;
        sb.push_back(model('{ready: 1'b0, zero: 1'b0, op: OP_X, fn: 6'd0,
                             st: S_FETCH, ill: 1'b0, to: 1'b0}, 6'd0, 1'b1));
        got = sample(); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL async_reset got=%h exp=%h", got, exp); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw_wait();
        test_back_to_back();
        test_jumps();
        test_branch();
        test_illegal();
        test_mem_timeout();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
